// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: merges NUM_PORTS L2 memory-side TileLink-UL A-channels into
// one registered A-channel using round-robin arbitration. Memory responds in
// order, so a grant-order FIFO steers each D beat back to the L2 that issued it.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_a_*                    per-L2 A channels, port i fields at [i*W +: W]
//   out_a_*                   registered merged A channel to memory
//   mem_d_*                   D channel from memory
//   out_d_*                   per-L2 D channels (payload broadcast to all slices)
//   resp_orphan               sticky flag: D beat seen while no request was in flight
//   perf_grant_cnt            per-port saturating grant counters, 32 bits each
//
// Optional feature: define L2MEM_ARB_PERF_EN to build the grant counters;
// otherwise perf_grant_cnt is tied to zero.
module l2_mem_arbiter #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned OP_BITS      = 3,
    parameter int unsigned SIZE_BITS    = 3,
    parameter int unsigned SOURCE_BITS  = 8,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned MASK_BITS    = 8,
    parameter int unsigned OUTSTANDING  = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_PORTS-1:0]              in_a_valid,
    output logic [NUM_PORTS-1:0]              in_a_ready,
    input  logic [NUM_PORTS*OP_BITS-1:0]      in_a_opcode,
    input  logic [NUM_PORTS*SIZE_BITS-1:0]    in_a_size,
    input  logic [NUM_PORTS*SOURCE_BITS-1:0]  in_a_source,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] in_a_address,
    input  logic [NUM_PORTS*MASK_BITS-1:0]    in_a_mask,
    input  logic [NUM_PORTS*DATA_BITS-1:0]    in_a_data,
    input  logic [NUM_PORTS*3-1:0]            in_a_param,
    output logic                              out_a_valid,
    input  logic                              out_a_ready,
    output logic [OP_BITS-1:0]                out_a_opcode,
    output logic [SIZE_BITS-1:0]              out_a_size,
    output logic [SOURCE_BITS-1:0]            out_a_source,
    output logic [ADDRESS_BITS-1:0]           out_a_address,
    output logic [MASK_BITS-1:0]              out_a_mask,
    output logic [DATA_BITS-1:0]              out_a_data,
    output logic [2:0]                        out_a_param,
    input  logic                              mem_d_valid,
    output logic                              mem_d_ready,
    input  logic [OP_BITS-1:0]                mem_d_opcode,
    input  logic [SIZE_BITS-1:0]              mem_d_size,
    input  logic [SOURCE_BITS-1:0]            mem_d_source,
    input  logic [DATA_BITS-1:0]              mem_d_data,
    input  logic [2:0]                        mem_d_param,
    output logic [NUM_PORTS-1:0]              out_d_valid,
    input  logic [NUM_PORTS-1:0]              out_d_ready,
    output logic [NUM_PORTS*OP_BITS-1:0]      out_d_opcode,
    output logic [NUM_PORTS*SIZE_BITS-1:0]    out_d_size,
    output logic [NUM_PORTS*SOURCE_BITS-1:0]  out_d_source,
    output logic [NUM_PORTS*DATA_BITS-1:0]    out_d_data,
    output logic [NUM_PORTS*3-1:0]            out_d_param,
    output logic                              resp_orphan,
    output logic [NUM_PORTS*32-1:0]           perf_grant_cnt
);

    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned FA_W   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = FA_W + 1;
    localparam int unsigned PARM_W = 3;

    // A slot registers
    logic                    a_valid_q;
    logic [OP_BITS-1:0]      a_opcode_q;
    logic [SIZE_BITS-1:0]    a_size_q;
    logic [SOURCE_BITS-1:0]  a_source_q;
    logic [ADDRESS_BITS-1:0] a_address_q;
    logic [MASK_BITS-1:0]    a_mask_q;
    logic [DATA_BITS-1:0]    a_data_q;
    logic [PARM_W-1:0]       a_param_q;

    // Arbitration and order FIFO state
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] fifo_q [OUTSTANDING];
    logic [FA_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             orphan_q;

    logic             slot_free, fifo_full, fifo_empty;
    logic             gnt_valid, push, pop;
    logic [PTR_W-1:0] gnt_idx, cand, head;

    logic [OP_BITS-1:0]      sel_opcode;
    logic [SIZE_BITS-1:0]    sel_size;
    logic [SOURCE_BITS-1:0]  sel_source;
    logic [ADDRESS_BITS-1:0] sel_address;
    logic [MASK_BITS-1:0]    sel_mask;
    logic [DATA_BITS-1:0]    sel_data;
    logic [PARM_W-1:0]       sel_param;

    assign slot_free  = ~a_valid_q | out_a_ready;
    assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_q];

    // Round-robin pick: first valid port after the last granted one.
    // A full FIFO blocks grants even if a pop lands in the same cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (slot_free && !fifo_full) begin
            for (int k = 1; k <= int'(NUM_PORTS); k++) begin
                cand = PTR_W'((32'(ptr_q) + 32'(k)) % NUM_PORTS);
                if (!gnt_valid && in_a_valid[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // One-hot ready towards the granted L2
    always_comb begin
        in_a_ready = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            in_a_ready[i] = gnt_valid && (gnt_idx == PTR_W'(i));
        end
    end

    // Payload mux of the granted port
    always_comb begin
        sel_opcode  = '0;
        sel_size    = '0;
        sel_source  = '0;
        sel_address = '0;
        sel_mask    = '0;
        sel_data    = '0;
        sel_param   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_opcode  = in_a_opcode[i*OP_BITS +: OP_BITS];
                sel_size    = in_a_size[i*SIZE_BITS +: SIZE_BITS];
                sel_source  = in_a_source[i*SOURCE_BITS +: SOURCE_BITS];
                sel_address = in_a_address[i*ADDRESS_BITS +: ADDRESS_BITS];
                sel_mask    = in_a_mask[i*MASK_BITS +: MASK_BITS];
                sel_data    = in_a_data[i*DATA_BITS +: DATA_BITS];
                sel_param   = in_a_param[i*PARM_W +: PARM_W];
            end
        end
    end

    // D steering: only the L2 at the FIFO head sees the beat
    always_comb begin
        out_d_valid = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            out_d_valid[i] = mem_d_valid && !fifo_empty && (head == PTR_W'(i));
        end
    end

    assign mem_d_ready = !fifo_empty && out_d_ready[head];
    assign push        = gnt_valid;
    assign pop         = mem_d_valid && mem_d_ready;

    always_comb begin
        ptr_d = gnt_valid ? gnt_idx : ptr_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A slot: loads whenever it is free, holds while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            a_param_q   <= '0;
        end else if (slot_free) begin
            a_valid_q <= gnt_valid;
            if (gnt_valid) begin
                a_opcode_q  <= sel_opcode;
                a_size_q    <= sel_size;
                a_source_q  <= sel_source;
                a_address_q <= sel_address;
                a_mask_q    <= sel_mask;
                a_data_q    <= sel_data;
                a_param_q   <= sel_param;
            end
        end
    end

    // Pointers, occupancy, round-robin pointer and orphan flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q    <= PTR_W'(NUM_PORTS - 1);
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push) begin
                wr_q <= wr_q + FA_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + FA_W'(1);
            end
            if (mem_d_valid && fifo_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

    // Order FIFO storage; entries are only read while occupied
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q] <= gnt_idx;
        end
    end

    assign out_a_valid   = a_valid_q;
    assign out_a_opcode  = a_opcode_q;
    assign out_a_size    = a_size_q;
    assign out_a_source  = a_source_q;
    assign out_a_address = a_address_q;
    assign out_a_mask    = a_mask_q;
    assign out_a_data    = a_data_q;
    assign out_a_param   = a_param_q;
    assign resp_orphan   = orphan_q;

    assign out_d_opcode = {NUM_PORTS{mem_d_opcode}};
    assign out_d_size   = {NUM_PORTS{mem_d_size}};
    assign out_d_source = {NUM_PORTS{mem_d_source}};
    assign out_d_data   = {NUM_PORTS{mem_d_data}};
    assign out_d_param  = {NUM_PORTS{mem_d_param}};

`ifdef L2MEM_ARB_PERF_EN
    logic [31:0] perf_q [NUM_PORTS];

    // Saturating per-port grant counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (gnt_valid && (gnt_idx == PTR_W'(i)) && (perf_q[i] != 32'hFFFF_FFFF)) begin
                    perf_q[i] <= perf_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            perf_grant_cnt[i*32 +: 32] = perf_q[i];
        end
    end
`else
    assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_l2_mem_arbiter;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      in_a_valid, in_a_ready;
    logic [N*3-1:0]    in_a_opcode, in_a_size, in_a_param;
    logic [N*8-1:0]    in_a_source, in_a_mask;
    logic [N*32-1:0]   in_a_address;
    logic [N*64-1:0]   in_a_data;
    logic              out_a_valid, out_a_ready;
    logic [2:0]        out_a_opcode, out_a_size, out_a_param;
    logic [7:0]        out_a_source, out_a_mask;
    logic [31:0]       out_a_address;
    logic [63:0]       out_a_data;
    logic              mem_d_valid, mem_d_ready;
    logic [2:0]        mem_d_opcode, mem_d_size, mem_d_param;
    logic [7:0]        mem_d_source;
    logic [63:0]       mem_d_data;
    logic [N-1:0]      out_d_valid, out_d_ready;
    logic [N*3-1:0]    out_d_opcode, out_d_size, out_d_param;
    logic [N*8-1:0]    out_d_source;
    logic [N*64-1:0]   out_d_data;
    logic              resp_orphan;
    logic [N*32-1:0]   perf_grant_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_opcode(in_a_opcode), .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .in_a_param(in_a_param),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_opcode(out_a_opcode), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_a_param(out_a_param),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready),
        .mem_d_opcode(mem_d_opcode), .mem_d_size(mem_d_size), .mem_d_source(mem_d_source),
        .mem_d_data(mem_d_data), .mem_d_param(mem_d_param),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_opcode(out_d_opcode), .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_data(out_d_data), .out_d_param(out_d_param),
        .resp_orphan(resp_orphan), .perf_grant_cnt(perf_grant_cnt)
    );

    task automatic drive_idle();
        in_a_valid   = '0;
        in_a_opcode  = '0;
        in_a_size    = '0;
        in_a_param   = '0;
        in_a_source  = '0;
        in_a_mask    = '0;
        in_a_address = '0;
        in_a_data    = '0;
        out_a_ready  = 1'b0;
        mem_d_valid  = 1'b0;
        mem_d_opcode = '0;
        mem_d_size   = '0;
        mem_d_param  = '0;
        mem_d_source = '0;
        mem_d_data   = '0;
        out_d_ready  = '0;
    endtask

    task automatic set_a(input int p, input logic [2:0] op, input logic [31:0] addr,
                         input logic [7:0] src);
        in_a_valid[p]          = 1'b1;
        in_a_opcode[p*3 +: 3]  = op;
        in_a_size[p*3 +: 3]    = 3'd3;
        in_a_param[p*3 +: 3]   = 3'd0;
        in_a_source[p*8 +: 8]  = src;
        in_a_mask[p*8 +: 8]    = 8'hFF;
        in_a_address[p*32 +: 32] = addr;
        in_a_data[p*64 +: 64]  = {~addr, addr};
    endtask

    // Returns n D beats with every L2 ready; called between negedge and posedge
    task automatic drain(input int n);
        mem_d_valid = 1'b1;
        out_d_ready = '1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        mem_d_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if (out_a_valid !== 1'b0 || out_a_address !== 32'h0 || out_a_opcode !== 3'h0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b addr=%h op=%h expected 0", out_a_valid, out_a_address, out_a_opcode);
        end
        checks++;
        if (resp_orphan !== 1'b0 || mem_d_ready !== 1'b0 || out_d_valid !== 2'b00 || perf_grant_cnt !== '0) begin
            errors++;
            $display("FAIL reset_d: got orphan=%b mem_d_ready=%b out_d_valid=%b perf=%h expected 0",
                     resp_orphan, mem_d_ready, out_d_valid, perf_grant_cnt);
        end
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_a_ready !== 2'b00 || out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle: got in_a_ready=%b out_a_valid=%b expected 00/0", in_a_ready, out_a_valid);
        end
    endtask

    task automatic test_single_read();
        set_a(1, 3'd4, 32'h9000_0000, 8'h21);
        #1;
        checks++;
        if (in_a_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: got %b expected 10", in_a_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_a_valid = '0;
        checks++;
        if (out_a_valid !== 1'b1 || out_a_opcode !== 3'd4 || out_a_address !== 32'h9000_0000 ||
            out_a_source !== 8'h21 || out_a_data !== {~32'h9000_0000, 32'h9000_0000}) begin
            errors++;
            $display("FAIL single_a: got v=%b op=%0d addr=%h src=%h expected 1/4/90000000/21",
                     out_a_valid, out_a_opcode, out_a_address, out_a_source);
        end
        // Stalled slot must hold its content
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_a_valid !== 1'b1 || out_a_address !== 32'h9000_0000) begin
            errors++;
            $display("FAIL single_hold: got v=%b addr=%h expected 1/90000000", out_a_valid, out_a_address);
        end
        out_a_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consume: got v=%b expected 0", out_a_valid);
        end
        mem_d_valid  = 1'b1;
        mem_d_opcode = 3'd1;
        mem_d_data   = 64'hDEAD_BEEF_0123_4567;
        out_d_ready  = 2'b11;
        #1;
        checks++;
        if (out_d_valid !== 2'b10 || mem_d_ready !== 1'b1 || out_d_opcode[5:3] !== 3'd1 ||
            out_d_data[127:64] !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL single_d: got out_d_valid=%b mem_d_ready=%b op=%0d expected 10/1/1",
                     out_d_valid, mem_d_ready, out_d_opcode[5:3]);
        end
        @(posedge clk);
        @(negedge clk);
        mem_d_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        logic [7:0] exp_src;
        set_a(0, 3'd4, 32'h1000, 8'h10);
        set_a(1, 3'd4, 32'h2000, 8'h11);
        out_a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_src = (i % 2 == 0) ? 8'h10 : 8'h11;
            checks++;
            if (in_a_ready !== exp_rdy) begin
                errors++;
                $display("FAIL contention_grant %0d: got %b expected %b", i, in_a_ready, exp_rdy);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_a_valid !== 1'b1 || out_a_source !== exp_src) begin
                errors++;
                $display("FAIL contention_a %0d: got v=%b src=%h expected 1/%h", i, out_a_valid, out_a_source, exp_src);
            end
        end
        in_a_valid = '0;
        @(posedge clk);
        @(negedge clk);
        drain(6);
    endtask

    task automatic test_order();
        int ports[3] = '{0, 1, 0};
        logic [2:0] ops[3] = '{3'd0, 3'd4, 3'd4};
        logic [1:0] exp;
        out_a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a_valid = '0;
            set_a(ports[i], ops[i], 32'h100 * (i + 1), 8'(8'h20 + i));
            #1;
            exp = 2'b01 << ports[i];
            checks++;
            if (in_a_ready !== exp) begin
                errors++;
                $display("FAIL order_grant %0d: got %b expected %b", i, in_a_ready, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_a_valid   = '0;
        mem_d_valid  = 1'b1;
        mem_d_opcode = 3'd0;
        out_d_ready  = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (out_d_valid !== 2'b01 || mem_d_ready !== 1'b0) begin
                errors++;
                $display("FAIL order_stall %0d: got out_d_valid=%b mem_d_ready=%b expected 01/0",
                         i, out_d_valid, mem_d_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_d_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = 2'b01 << ports[i];
            checks++;
            if (out_d_valid !== exp || mem_d_ready !== 1'b1) begin
                errors++;
                $display("FAIL order_route %0d: got out_d_valid=%b mem_d_ready=%b expected %b/1",
                         i, out_d_valid, mem_d_ready, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_d_valid = 1'b0;
    endtask

    task automatic test_full();
        drive_idle();
        set_a(0, 3'd4, 32'h400, 8'h30);
        out_a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (in_a_ready !== 2'b01) begin
                errors++;
                $display("FAIL full_fill %0d: got %b expected 01", i, in_a_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_a_ready !== 2'b00) begin
                errors++;
                $display("FAIL full_hold %0d: got %b expected 00", i, in_a_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_d_valid = 1'b1;
        out_d_ready = 2'b11;
        #1;
        checks++;
        if (in_a_ready !== 2'b00 || mem_d_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_nobypass: got in_a_ready=%b mem_d_ready=%b expected 00/1", in_a_ready, mem_d_ready);
        end
        @(posedge clk);
        @(negedge clk);
        mem_d_valid = 1'b0;
        #1;
        checks++;
        if (in_a_ready !== 2'b01) begin
            errors++;
            $display("FAIL full_release: got %b expected 01", in_a_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_a_valid = '0;
        @(posedge clk);
        @(negedge clk);
        drain(8);
    endtask

    task automatic test_orphan_perf();
        logic [31:0] exp_cnt;
        apply_reset();
        set_a(0, 3'd4, 32'h500, 8'h40);
        out_a_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_a_valid = '0;
`ifdef L2MEM_ARB_PERF_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (perf_grant_cnt[31:0] !== exp_cnt || perf_grant_cnt[63:32] !== 32'd0) begin
            errors++;
            $display("FAIL perf_cnt: got p0=%0d p1=%0d expected %0d/0",
                     perf_grant_cnt[31:0], perf_grant_cnt[63:32], exp_cnt);
        end
        // Reset with requests in flight drops them all
        rstn        = 1'b0;
        mem_d_valid = 1'b1;
        out_d_ready = 2'b11;
        #1;
        checks++;
        if (out_a_valid !== 1'b0 || mem_d_ready !== 1'b0 || out_d_valid !== 2'b00) begin
            errors++;
            $display("FAIL midreset: got out_a_valid=%b mem_d_ready=%b out_d_valid=%b expected 0/0/00",
                     out_a_valid, mem_d_ready, out_d_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (mem_d_ready !== 1'b0 || out_d_valid !== 2'b00 || resp_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_route: got mem_d_ready=%b out_d_valid=%b orphan=%b expected 0/00/0",
                     mem_d_ready, out_d_valid, resp_orphan);
        end
        @(posedge clk);
        @(negedge clk);
        mem_d_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (resp_orphan !== 1'b1) begin
                errors++;
                $display("FAIL orphan_sticky %0d: got %b expected 1", i, resp_orphan);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Transaction-level model: the FIFO is a queue of granted port numbers
    task automatic test_random(input int cycles);
        int          ptr;
        int          q[$];
        int          g;
        logic        sv;
        logic [2:0]  sop;
        logic [7:0]  ssrc;
        logic [31:0] sadr;
        logic [63:0] sdat;
        logic [N-1:0] exp_rdy, exp_dv;
        logic        exp_mr;
        logic        free;
        apply_reset();
        ptr = N - 1;
        q   = {};
        sv  = 1'b0;
        sop = '0; ssrc = '0; sadr = '0; sdat = '0;
        for (int c = 0; c < cycles; c++) begin
            checks++;
            if (out_a_valid !== sv || (sv && (out_a_opcode !== sop || out_a_source !== ssrc ||
                out_a_address !== sadr || out_a_data !== sdat))) begin
                errors++;
                $display("FAIL rnd_a cycle %0d: got v=%b op=%0d src=%h addr=%h expected v=%b op=%0d src=%h addr=%h",
                         c, out_a_valid, out_a_opcode, out_a_source, out_a_address, sv, sop, ssrc, sadr);
            end
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_a(p, 3'($urandom_range(0, 7)), $urandom, 8'($urandom_range(0, 255)));
                end else begin
                    in_a_valid[p] = 1'b0;
                end
            end
            out_a_ready  = ($urandom_range(0, 3) != 0);
            mem_d_valid  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_d_opcode = 3'($urandom_range(0, 7));
            mem_d_source = 8'($urandom_range(0, 255));
            mem_d_data   = {$urandom, $urandom};
            out_d_ready  = 2'($urandom_range(0, 3));
            #1;
            free = !sv || out_a_ready;
            g = -1;
            if (free && q.size() < 8) begin
                for (int k = 1; k <= N; k++) begin
                    int pp;
                    pp = (ptr + k) % N;
                    if (g < 0 && in_a_valid[pp]) g = pp;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            exp_dv = '0;
            exp_mr = 1'b0;
            if (q.size() > 0) begin
                exp_mr = out_d_ready[q[0]];
                exp_dv[q[0]] = mem_d_valid;
            end
            checks++;
            if (in_a_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready cycle %0d: got %b expected %b", c, in_a_ready, exp_rdy);
            end
            checks++;
            if (out_d_valid !== exp_dv || mem_d_ready !== exp_mr ||
                out_d_source[15:8] !== mem_d_source || out_d_data[63:0] !== mem_d_data) begin
                errors++;
                $display("FAIL rnd_d cycle %0d: got dv=%b mr=%b expected dv=%b mr=%b",
                         c, out_d_valid, mem_d_ready, exp_dv, exp_mr);
            end
            if (mem_d_valid && exp_mr) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(g);
                ptr  = g;
                sv   = 1'b1;
                sop  = in_a_opcode[g*3 +: 3];
                ssrc = in_a_source[g*8 +: 8];
                sadr = in_a_address[g*32 +: 32];
                sdat = in_a_data[g*64 +: 64];
            end else if (free) begin
                sv = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (resp_orphan !== 1'b0) begin
            errors++;
            $display("FAIL rnd_orphan: got %b expected 0", resp_orphan);
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_order();
        test_full();
        test_orphan_perf();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
